neuron_weight_ctrl: RTL

//  Sequencer and arbiter for one neuron's weight memory (1-cycle registered read, separate write port).

---
 rtl/neuron_weight_ctrl_pkg.sv | 25 ++
 rtl/neuron_weight_ctrl_if.sv | 45 ++++
 rtl/neuron_weight_ctrl_fifo.sv | 63 ++++++
 rtl/neuron_weight_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/neuron_weight_ctrl_pkg.sv
// Shared definitions for the neuron weight sequencer: state encoding,
// default sizing and the read-issue occupancy helper.
package neuron_weight_ctrl_pkg;

    localparam int NUM_WEIGHTS_DEF = 784;
    localparam int ADDR_WIDTH_DEF  = 10;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam bit PRE_TRAINED_DEF = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Words held or on their way once this cycle's pop has left.
    function automatic logic [2:0] occupancy(
        input logic [1:0] cnt,
        input logic       inflight,
        input logic       pop
    );
        return 3'(cnt) + 3'(inflight) - 3'(pop);
    endfunction

endpackage

// File: rtl/neuron_weight_ctrl_if.sv
// Bundle of config, weight-stream and memory-port signals between the
// weight sequencer (master) and its surroundings (slave).
interface neuron_weight_ctrl_if
    import neuron_weight_ctrl_pkg::*;
#(
    parameter int AW = ADDR_WIDTH_DEF,
    parameter int DW = DATA_WIDTH_DEF
);
    logic          i_cfg_valid;
    logic          o_cfg_ready;
    logic [AW-1:0] i_cfg_addr;
    logic [DW-1:0] i_cfg_data;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic          o_w_valid;
    logic          i_w_ready;
    logic [DW-1:0] o_w_data;
    logic          o_w_last;
    logic          o_mem_w_en;
    logic [AW-1:0] o_mem_w_addr;
    logic [DW-1:0] o_mem_w_data;
    logic          o_mem_r_en;
    logic [AW-1:0] o_mem_r_addr;
    logic [DW-1:0] i_mem_data;

    modport master (
        input  i_cfg_valid, i_cfg_addr, i_cfg_data, i_start,
        input  i_w_ready, i_mem_data,
        output o_cfg_ready, o_busy, o_done,
        output o_w_valid, o_w_data, o_w_last,
        output o_mem_w_en, o_mem_w_addr, o_mem_w_data,
        output o_mem_r_en, o_mem_r_addr
    );

    modport slave (
        output i_cfg_valid, i_cfg_addr, i_cfg_data, i_start,
        output i_w_ready, i_mem_data,
        input  o_cfg_ready, o_busy, o_done,
        input  o_w_valid, o_w_data, o_w_last,
        input  o_mem_w_en, o_mem_w_addr, o_mem_w_data,
        input  o_mem_r_en, o_mem_r_addr
    );

endinterface

// File: rtl/neuron_weight_ctrl_fifo.sv
// Two-entry output FIFO carrying {last, data}; entry 0 is always the head
// so the stream outputs stay stable while the consumer stalls.
module weight_skid_fifo #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          push_last,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic          head_last,
    output logic [DW-1:0] head_data
);

    logic [DW:0] e0_q, e0_d;
    logic [DW:0] e1_q, e1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [DW:0] din;
    logic        pop_ok;

    assign din    = {push_last, push_data};
    assign pop_ok = pop && (cnt_q != 2'd0);

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (pop_ok && push) begin
            if (cnt_q == 2'd1) begin
                e0_d = din;
            end else begin
                e0_d = e1_q;
                e1_d = din;
            end
        end else if (pop_ok) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end else if (push && (cnt_q != 2'd2)) begin
            if (cnt_q == 2'd0) e0_d = din;
            else               e1_d = din;
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count     = cnt_q;
    assign head_last = e0_q[DW];
    assign head_data = e0_q[DW-1:0];

endmodule

// File: rtl/neuron_weight_ctrl.sv
// Weight memory sequencer: config writes while idle, then on start a
// backpressured sweep of addresses 0..NUM_WEIGHTS-1 to the neuron MAC.
module neuron_weight_ctrl
    import neuron_weight_ctrl_pkg::*;
#(
    parameter int NUM_WEIGHTS = NUM_WEIGHTS_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter bit PRE_TRAINED = PRE_TRAINED_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    neuron_weight_ctrl_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);
    localparam logic [ADDR_WIDTH:0]   NW_EXT    = (ADDR_WIDTH + 1)'(NUM_WEIGHTS);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  inlast_q, inlast_d;
    logic                  done_q, done_d;

    logic [1:0]            f_cnt;
    logic                  f_last;
    logic [DATA_WIDTH-1:0] f_data;
    logic                  f_valid;
    logic                  pop;
    logic                  issue;
    logic                  at_end;
    logic                  cfg_ready;
    logic                  cfg_fire;
    logic                  wr_en;

    assign f_valid = (f_cnt != 2'd0);
    assign pop     = f_valid && bus.i_w_ready;
    assign at_end  = (cnt_q == LAST_ADDR);
    // A read is only issued if its word is guaranteed a FIFO slot.
    assign issue   = (state_q == ST_READ)
                   && (occupancy(f_cnt, inflight_q, pop) < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            inlast_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            inlast_q   <= inlast_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (at_end) state_d = ST_DRAIN;
                    else        cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (pop && f_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        inflight_d = issue;
        inlast_d   = issue && at_end;
        done_d     = (state_q == ST_DRAIN) && pop && f_last;
        cfg_ready  = !PRE_TRAINED && (state_q == ST_IDLE) && !bus.i_start;
        cfg_fire   = bus.i_cfg_valid && cfg_ready;
        wr_en      = cfg_fire && ({1'b0, bus.i_cfg_addr} < NW_EXT);
    end

    weight_skid_fifo #(
        .DW (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_last (inlast_q),
        .push_data (bus.i_mem_data),
        .pop       (pop),
        .count     (f_cnt),
        .head_last (f_last),
        .head_data (f_data)
    );

    assign bus.o_cfg_ready  = cfg_ready;
    assign bus.o_mem_w_en   = wr_en;
    assign bus.o_mem_w_addr = wr_en ? bus.i_cfg_addr : '0;
    assign bus.o_mem_w_data = wr_en ? bus.i_cfg_data : '0;
    assign bus.o_mem_r_en   = issue;
    assign bus.o_mem_r_addr = cnt_q;
    assign bus.o_busy       = (state_q != ST_IDLE) || done_q;
    assign bus.o_done       = done_q;
    assign bus.o_w_valid    = f_valid;
    assign bus.o_w_data     = f_valid ? f_data : '0;
    assign bus.o_w_last     = f_valid && f_last;

endmodule
